// File: rtl/spi_pkg.sv
// Shared types and frame geometry for the serial-link memory target.
package spi_pkg;

  localparam int unsigned WR_FRAME_BITS = 17;
  localparam int unsigned RD_FRAME_BITS = 9;
  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned CNT_W         = 5;
  localparam int unsigned STAT_W        = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftIn,
    StCommitWr,
    StTurnaround,
    StShiftOut
  } spi_tgt_state_t;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/spi_tgt_regfile.sv
// DEPTH x 8 register file: synchronous write, combinational read, synchronous clear on reset.
module spi_tgt_regfile
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_memory_target.sv
// Peripheral end of the clk-synchronous serial link with a DEPTH x 8 register file.
// Optional statistics counters (wr_cnt/rd_cnt/err_cnt) are built when SPI_TGT_STATS_EN is defined.
module spi_memory_target
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              ready,
  output logic              op_done,
  output logic              frame_err,
  output logic              addr_err
`ifdef SPI_TGT_STATS_EN
  ,
  output logic [STAT_W-1:0] wr_cnt,
  output logic [STAT_W-1:0] rd_cnt,
  output logic [STAT_W-1:0] err_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TA_W  = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  spi_tgt_state_t           state_q, state_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WR_FRAME_BITS-1:0] frame_q, frame_d;
  logic [TA_W-1:0]          ta_cnt_q, ta_cnt_d;
  logic [3:0]               out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0]        rd_byte_q, rd_byte_d;
  logic                     miso_q, miso_d;
  logic                     ready_q, ready_d;
  logic                     op_done_q, op_done_d;
  logic                     frame_err_q, frame_err_d;
  logic                     addr_err_q, addr_err_d;

  logic                     wr_flag;
  logic [ADDR_W-1:0]        frm_addr;
  logic [DATA_W-1:0]        frm_data;
  logic                     addr_ok;
  logic                     rf_we;
  logic [DATA_W-1:0]        rf_rdata;

  assign wr_flag  = frame_q[0];
  assign frm_addr = frame_q[ADDR_W:1];
  assign frm_data = frame_q[ADDR_W+DATA_W:ADDR_W+1];
  assign addr_ok  = 32'(frm_addr) < DEPTH;

  spi_tgt_regfile #(
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (rf_we),
    .waddr(frm_addr[IDX_W-1:0]),
    .wdata(frm_data),
    .raddr(frm_addr[IDX_W-1:0]),
    .rdata(rf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    ta_cnt_d    = ta_cnt_q;
    out_cnt_d   = out_cnt_q;
    rd_byte_d   = rd_byte_q;
    miso_d      = 1'b0;
    ready_d     = 1'b0;
    op_done_d   = 1'b0;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;
    rf_we       = 1'b0;

    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        frame_d   = '0;
        // This edge is the discarded setup edge of the frame.
        if (!cs_n) state_d = StSetup;
      end

      StSetup, StShiftIn: begin
        if (!cs_n) begin
          if (bit_cnt_q < CNT_W'(WR_FRAME_BITS)) begin
            frame_d[bit_cnt_q] = mosi;
            bit_cnt_d          = bit_cnt_q + 1'b1;
          end
          state_d = StShiftIn;
        end else if (wr_flag && (bit_cnt_q == CNT_W'(WR_FRAME_BITS))) begin
          state_d = StCommitWr;
        end else if (!wr_flag && (bit_cnt_q == CNT_W'(RD_FRAME_BITS))) begin
          state_d  = StTurnaround;
          ta_cnt_d = '0;
        end else begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end
      end

      StCommitWr: begin
        rf_we      = addr_ok;
        op_done_d  = 1'b1;
        addr_err_d = !addr_ok;
        state_d    = StIdle;
      end

      StTurnaround: begin
        if (ta_cnt_q == TA_W'(TURNAROUND - 1)) begin
          ready_d    = 1'b1;
          addr_err_d = !addr_ok;
          rd_byte_d  = addr_ok ? rf_rdata : '0;
          miso_d     = rd_byte_d[0];
          out_cnt_d  = '0;
          state_d    = StShiftOut;
        end else begin
          ta_cnt_d = ta_cnt_q + 1'b1;
        end
      end

      StShiftOut: begin
        // b0 is held for two cycles (ready cycle and the one after), then b1..b7.
        if (out_cnt_q == 4'd8) begin
          state_d = StIdle;
        end else begin
          miso_d    = rd_byte_q[out_cnt_q[2:0]];
          out_cnt_d = out_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      ta_cnt_q    <= '0;
      out_cnt_q   <= '0;
      rd_byte_q   <= '0;
      miso_q      <= 1'b0;
      ready_q     <= 1'b0;
      op_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      ta_cnt_q    <= ta_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rd_byte_q   <= rd_byte_d;
      miso_q      <= miso_d;
      ready_q     <= ready_d;
      op_done_q   <= op_done_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign miso      = miso_q;
  assign ready     = ready_q;
  assign op_done   = op_done_q;
  assign frame_err = frame_err_q;
  assign addr_err  = addr_err_q;

`ifdef SPI_TGT_STATS_EN
  logic [STAT_W-1:0] wr_cnt_q, rd_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= sat_inc(wr_cnt_q, op_done_d && !addr_err_d);
      rd_cnt_q  <= sat_inc(rd_cnt_q, ready_d && !addr_err_d);
      err_cnt_q <= sat_inc(err_cnt_q, frame_err_d || addr_err_d);
    end
  end

  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_memory_target.sv
// Directed self-checking bench for spi_memory_target (DEPTH=32, TURNAROUND=1).
module tb_spi_memory_target;

  localparam int unsigned TA = 1;

  logic clk = 1'b0;
  logic rst_n, cs_n, mosi;
  logic miso, ready, op_done, frame_err, addr_err;
`ifdef SPI_TGT_STATS_EN
  logic [15:0] wr_cnt, rd_cnt, err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_memory_target #(
    .DEPTH     (32),
    .TURNAROUND(TA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .ready    (ready),
    .op_done  (op_done),
    .frame_err(frame_err),
    .addr_err (addr_err)
`ifdef SPI_TGT_STATS_EN
    ,
    .wr_cnt   (wr_cnt),
    .rd_cnt   (rd_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_bit({tag, "_miso"}, miso, 1'b0);
    check_bit({tag, "_ready"}, ready, 1'b0);
    check_bit({tag, "_op_done"}, op_done, 1'b0);
    check_bit({tag, "_frame_err"}, frame_err, 1'b0);
    check_bit({tag, "_addr_err"}, addr_err, 1'b0);
  endtask

  // Setup edge, nbits data edges, then the cs_n-high edge; returns just after that edge.
  task automatic send_frame(input logic [16:0] bits, input int nbits);
    cs_n = 1'b0;
    cyc();
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[i];
      cyc();
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    cyc();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic exp_aerr);
    send_frame({d, a, 1'b1}, 17);
    check_bit($sformatf("wr_early_op_done@%0h", a), op_done, 1'b0);
    cyc();
    check_bit($sformatf("wr_op_done@%0h", a), op_done, 1'b1);
    check_bit($sformatf("wr_addr_err@%0h", a), addr_err, exp_aerr);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input logic exp_aerr);
    logic [7:0] got;
    got = '0;
    send_frame({8'h00, a, 1'b0}, 9);
    for (int i = 0; i < int'(TA); i++) begin
      check_bit($sformatf("rd_ready_early@%0h", a), ready, 1'b0);
      cyc();
    end
    check_bit($sformatf("rd_ready@%0h", a), ready, 1'b1);
    check_bit($sformatf("rd_addr_err@%0h", a), addr_err, exp_aerr);
    check_bit($sformatf("rd_miso_b0_R@%0h", a), miso, exp[0]);
    for (int k = 0; k < 8; k++) begin
      cyc();
      got[k] = miso;
      if (k == 0) check_bit($sformatf("rd_ready_off@%0h", a), ready, 1'b0);
    end
    check_word($sformatf("rd_byte@%0h", a), {8'h00, got}, {8'h00, exp});
    cyc();
    check_bit($sformatf("rd_miso_tail@%0h", a), miso, 1'b0);
  endtask

  initial begin
    logic [16:0] wbits;
    logic [7:0]  d1;
    rst_n = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;

    // 1: reset state, then read of an untouched address.
    cyc();
    cyc();
    check_idle_outputs("reset");
`ifdef SPI_TGT_STATS_EN
    check_word("reset_wr_cnt", wr_cnt, 16'h0);
    check_word("reset_rd_cnt", rd_cnt, 16'h0);
    check_word("reset_err_cnt", err_cnt, 16'h0);
`endif
    rst_n = 1'b1;
    cyc();
    do_read(8'd5, 8'h00, 1'b0);

    // 2: write 0xA5 to addr 3 and read it back.
    do_write(8'd3, 8'hA5, 1'b0);
    cyc();
    check_bit("wr_op_done_pulse_end", op_done, 1'b0);
    do_read(8'd3, 8'hA5, 1'b0);

    // 3: out-of-range address; addr 8 would alias 40 if the address were truncated.
    do_write(8'd40, 8'hFF, 1'b1);
    do_read(8'd40, 8'h00, 1'b1);
    do_read(8'd8, 8'h00, 1'b0);

    // 4: malformed frames leave the file untouched.
    send_frame({8'h5A, 8'h03, 1'b1}, 12);
    check_bit("short_wr_frame_err", frame_err, 1'b1);
    cyc();
    check_bit("short_wr_frame_err_end", frame_err, 1'b0);
    check_bit("short_wr_no_op_done", op_done, 1'b0);
    cs_n = 1'b0;
    cyc();
    cs_n = 1'b1;
    cyc();
    check_bit("zero_bit_frame_err", frame_err, 1'b1);
    send_frame({8'h00, 8'h03, 1'b0}, 17);
    check_bit("long_rd_frame_err", frame_err, 1'b1);
    cyc();
    check_bit("long_rd_no_ready", ready, 1'b0);
    do_read(8'd3, 8'hA5, 1'b0);

    // 5: reset during bit 10 of a write of 0x3C to addr 7.
    wbits = {8'h3C, 8'h07, 1'b1};
    cs_n  = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      mosi = wbits[i];
      cyc();
    end
    mosi  = wbits[10];
    rst_n = 1'b0;
    cyc();
    check_idle_outputs("midframe_reset");
    cs_n = 1'b1;
    mosi = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    check_idle_outputs("post_reset");
    do_read(8'd7, 8'h00, 1'b0);
    do_read(8'd3, 8'h00, 1'b0);

    // 6: write/read/write sweep over every address with 2-cycle cs_n gaps.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int a = 0; a < 32; a++) begin
      d1 = 8'(a * 37 + 11);
      do_write(8'(a), d1, 1'b0);
      do_read(8'(a), d1, 1'b0);
      do_write(8'(a), ~d1, 1'b0);
    end
`ifdef SPI_TGT_STATS_EN
    check_word("sweep_wr_cnt", wr_cnt, 16'd64);
    check_word("sweep_rd_cnt", rd_cnt, 16'd32);
    check_word("sweep_err_cnt", err_cnt, 16'd0);
`endif
    do_read(8'd0, ~8'd11, 1'b0);
    do_read(8'd31, ~8'(31 * 37 + 11), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
